// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared exponent-path constants, FSM state and result types.
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int EXP_BIAS = 127;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        BIAS,
        DONE
    } exp_state_t;

    typedef struct packed {
        logic [EXP_W-1:0] s;
        logic             ovf;
        logic             unf;
    } exp_result_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/exp_adder_serial.sv
// rtl/exp_adder_serial.sv - bit-serial R = A + B - BIAS exponent combiner, saturated N-bit result.
// Optional EXP_SUB_MODE_EN adds an op input selecting R = A - B + BIAS.
module exp_adder_serial
    import fpu_pkg::*;
#(
    parameter int N    = EXP_W,
    parameter int BIAS = EXP_BIAS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
`ifdef EXP_SUB_MODE_EN
    input  logic         op,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         ovf,
    output logic         unf,
    output logic         busy
);

    localparam int              W      = N + 2;
    localparam int              CW     = $clog2(W);
    localparam logic [CW-1:0]   LAST   = CW'(W - 1);
    localparam logic [W-1:0]    BIAS_W = W'(BIAS);
    localparam logic [W-1:0]    SAT_W  = W'((1 << N) - 1);

    exp_state_t    state_q, state_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  s_q, s_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
`ifdef EXP_SUB_MODE_EN
    logic          sub_q, sub_d;
`endif

    logic          fa_a, fa_sum, fa_cout;
    logic [W-1:0]  acc_shift;

    // The BIAS state literal is package-qualified because the parameter BIAS shadows it.
    assign fa_a      = (state_q == fpu_pkg::BIAS) ? acc_q[0] : opa_q[0];
    assign acc_shift = {fa_sum, acc_q[W-1:1]};

    full_adder u_fa (
        .a     (fa_a),
        .b     (opb_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
`ifdef EXP_SUB_MODE_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = W'(A);
                    opb_d   = W'(B);
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
`ifdef EXP_SUB_MODE_EN
                    sub_d = op;
                    if (op) begin
                        opb_d   = ~W'(B);
                        carry_d = 1'b1;
                    end
`endif
                end
            end
            ADD: begin
                acc_d   = acc_shift;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Second pass subtracts BIAS as acc + ~BIAS + 1.
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    opb_d   = ~BIAS_W;
                    state_d = fpu_pkg::BIAS;
`ifdef EXP_SUB_MODE_EN
                    if (sub_q) begin
                        carry_d = 1'b0;
                        opb_d   = BIAS_W;
                    end
`endif
                end
            end
            fpu_pkg::BIAS: begin
                acc_d   = acc_shift;
                opb_d   = opb_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (acc_shift[W-1] || (acc_shift == '0)) begin
                        s_d   = '0;
                        ovf_d = 1'b0;
                        unf_d = 1'b1;
                    end else if (acc_shift >= SAT_W) begin
                        s_d   = '1;
                        ovf_d = 1'b1;
                        unf_d = 1'b0;
                    end else begin
                        s_d   = acc_shift[N-1:0];
                        ovf_d = 1'b0;
                        unf_d = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`ifdef EXP_SUB_MODE_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
`ifdef EXP_SUB_MODE_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ADD) || (state_q == fpu_pkg::BIAS);
    assign S         = s_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_exp_adder_serial.sv
// tb/tb_exp_adder_serial.sv - scoreboard bench for exp_adder_serial with an arithmetic reference model.
module tb_exp_adder_serial;

    localparam int N    = 8;
    localparam int BIAS = 127;
    localparam int LAT  = 2 * N + 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
`ifdef EXP_SUB_MODE_EN
    logic         op = 1'b0;
`endif
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] S;
    logic         ovf, unf, busy;

    always #5 clk = ~clk;

    exp_adder_serial #(.N(N), .BIAS(BIAS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
`ifdef EXP_SUB_MODE_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .ovf       (ovf),
        .unf       (unf),
        .busy      (busy)
    );

    typedef struct {
        logic [N-1:0] s;
        logic         o;
        logic         u;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   hold_low = 1'b0;
    bit   rand_ready = 1'b0;
    bit   prev_valid = 1'b0;
    bit   chk_ir = 1'b0;
    int   rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, then saturate to the N-bit exponent range.
    function automatic exp_t model(int a, int b, int o);
        exp_t e;
        int   r;
        r = (o != 0) ? (a - b + BIAS) : (a + b - BIAS);
        e.acc = 0;
        if (r <= 0) begin
            e.s = '0; e.o = 1'b0; e.u = 1'b1;
        end else if (r >= (1 << N) - 1) begin
            e.s = '1; e.o = 1'b1; e.u = 1'b0;
        end else begin
            e.s = N'(r); e.o = 1'b0; e.u = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (hold_low)        out_ready = 1'b0;
        else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        else                 out_ready = 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_ir) begin
            check("in_ready_after_handshake", in_ready, 1);
            chk_ir = 1'b0;
        end
        if (!rst && out_valid) begin
            if (!prev_valid) rise_cyc = cyc;
            check("in_ready_low_in_done", in_ready, 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got S=%0d with no pending operation", S);
            end else if (out_ready) begin
                e = q.pop_front();
                check("S", S, e.s);
                check("ovf", ovf, e.o);
                check("unf", unf, e.u);
                check("latency", rise_cyc - e.acc, LAT);
                chk_ir = 1'b1;
            end else begin
                check("S_hold", S, q[0].s);
                check("ovf_hold", ovf, q[0].o);
                check("unf_hold", unf, q[0].u);
            end
        end
        prev_valid = out_valid;
    end

    task automatic do_op(int a, int b, int o, bit push);
        int   t = 0;
        exp_t e;
        @(negedge clk);
        A = N'(a);
        B = N'(b);
`ifdef EXP_SUB_MODE_EN
        op = o[0];
`endif
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e = model(a, b, o);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = N'($urandom);
        B = N'($urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() > 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int dir_a[12] = '{130, 254, 254,  64, 100, 200,   0, 255,   0,   0, 127, 128};
        int dir_b[12] = '{127, 127, 128,  63,  20, 200,   0, 255, 127, 128, 254, 126};
        int t;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_S", S, 0);
        check("reset_ovf", ovf, 0);
        check("reset_unf", unf, 0);
        check("reset_busy", busy, 0);

        for (int i = 0; i < 12; i++) do_op(dir_a[i], dir_b[i], 0, 1'b1);
        wait_drain();

        @(negedge clk);
        hold_low = 1'b1;
        do_op(127, 127, 0, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        hold_low = 1'b0;
        wait_drain();

        do_op(130, 127, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("busy_in_add", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_S", S, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        do_op(1, 127, 0, 1'b1);
        wait_drain();

`ifdef EXP_SUB_MODE_EN
        do_op(10, 200, 1, 1'b1);
        do_op(200, 10, 1, 1'b1);
        do_op(140, 130, 1, 1'b1);
        do_op(130, 140, 0, 1'b1);
        wait_drain();
`endif

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int o = 0;
`ifdef EXP_SUB_MODE_EN
            o = int'($urandom_range(0, 1));
`endif
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), o, 1'b1);
        end
        wait_drain();
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
